// File: rtl/game_timer_pkg.sv
// Shared types, widths and the BCD incrementer for the Saper game timer.
package game_timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        PAUSED,
        STOPPED
    } timer_state_t;

    localparam int BCD_W = 12;

    // Three-digit BCD increment: each digit rolls 9 -> 0 and carries into the next.
    function automatic logic [11:0] bcd_inc3(input logic [11:0] value);
        logic [3:0] units;
        logic [3:0] tens;
        logic [3:0] hundreds;
        units    = value[3:0];
        tens     = value[7:4];
        hundreds = value[11:8];
        if (units == 4'd9) begin
            units = 4'd0;
            if (tens == 4'd9) begin
                tens = 4'd0;
                if (hundreds == 4'd9) begin
                    hundreds = 4'd0;
                end else begin
                    hundreds = hundreds + 4'd1;
                end
            end else begin
                tens = tens + 4'd1;
            end
        end else begin
            units = units + 4'd1;
        end
        return {hundreds, tens, units};
    endfunction

endpackage

// File: rtl/game_timer_if.sv
// Control and display signals between the game logic and the timer.
interface game_timer_if;
    import game_timer_pkg::*;

    logic             start;
    logic             pause;
    logic             game_over;
    logic             clear;
    logic             tick;
    logic             running;
    logic [BCD_W-1:0] seconds_bcd;
    logic [9:0]       seconds_bin;
    logic             saturated;

    // Game logic side: issues requests, observes the timer.
    modport master (
        output start, pause, game_over, clear,
        input  tick, running, seconds_bcd, seconds_bin, saturated
    );

    // Timer side.
    modport slave (
        input  start, pause, game_over, clear,
        output tick, running, seconds_bcd, seconds_bin, saturated
    );

endinterface

// File: rtl/game_timer_tick_prescaler.sv
// Period divider: counts enabled cycles 0..DIV-1 and flags the last one.
module tick_prescaler #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic load0,
    output logic wrap
);

    localparam int            CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign wrap = en && (cnt == LAST);

    // Advance only when enabled; a load request restarts the period from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load0) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/game_timer.sv
// Game elapsed-time source: run/pause/stop FSM, per-period tick and a
// saturating seconds count kept in both BCD and binary.
module game_timer
    import game_timer_pkg::*;
#(
    parameter int CLK_HZ      = 65_000_000,
    parameter int TICK_HZ     = 1,
    parameter int MAX_SECONDS = 999
) (
    input  logic         clk,
    input  logic         rst_n,
    game_timer_if.slave  bus
);

    localparam int         DIV     = CLK_HZ / TICK_HZ;
    localparam logic [9:0] MAX_BIN = 10'(MAX_SECONDS);

    timer_state_t state;
    logic         presc_en;
    logic         presc_load0;
    logic         presc_wrap;

    // Prescaler runs only while RUNNING and nothing is about to leave RUNNING.
    assign presc_en    = (state == RUNNING) && !bus.clear && !bus.game_over && !bus.pause;
    assign presc_load0 = bus.clear || ((state == IDLE) && bus.start);

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (presc_en),
        .load0 (presc_load0),
        .wrap  (presc_wrap)
    );

    // State machine, registered outputs and the seconds count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.tick        <= 1'b0;
            bus.running     <= 1'b0;
            bus.seconds_bcd <= '0;
            bus.seconds_bin <= '0;
            bus.saturated   <= 1'b0;
        end else begin
            bus.tick <= presc_wrap;
            if (bus.clear) begin
                state           <= IDLE;
                bus.running     <= 1'b0;
                bus.seconds_bcd <= '0;
                bus.seconds_bin <= '0;
                bus.saturated   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state       <= RUNNING;
                            bus.running <= 1'b1;
                        end
                    end
                    RUNNING: begin
                        if (bus.game_over) begin
                            state       <= STOPPED;
                            bus.running <= 1'b0;
                        end else if (bus.pause) begin
                            state       <= PAUSED;
                            bus.running <= 1'b0;
                        end
                    end
                    PAUSED: begin
                        if (bus.game_over) begin
                            state <= STOPPED;
                        end else if (!bus.pause) begin
                            state       <= RUNNING;
                            bus.running <= 1'b1;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
                // NOTE: bus.tick here reads the value registered on the previous
                // edge (non-blocking), so the count moves one cycle after the tick.
                if (bus.tick && (bus.seconds_bin != MAX_BIN)) begin
                    bus.seconds_bcd <= bcd_inc3(bus.seconds_bcd);
                    bus.seconds_bin <= bus.seconds_bin + 10'd1;
                    bus.saturated   <= (bus.seconds_bin + 10'd1 == MAX_BIN);
                end
            end
        end
    end

endmodule

// File: doc/game_timer.md
# game_timer

Elapsed-time source for the Saper game. Generates a one-cycle `tick` pulse at `TICK_HZ` while a game is in progress and keeps a saturating 3-digit BCD seconds count for the on-screen timer. `tick` is the event input of the downstream `counter` instance (its `counting` input). `seconds_bcd` feeds the digit-drawing logic.

## Interface
- `CLK_HZ`, 65_000_000: frequency of `clk` in Hz.
- `TICK_HZ`, 1: tick rate in Hz. `DIV = CLK_HZ/TICK_HZ` must be ≥ 2 and an integer.
- `MAX_SECONDS`, 999: saturation value. Must be ≤ 999.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: one-cycle request to begin timing; the first board click.
- `pause` in 1: level; freezes timing while high in RUNNING.
- `game_over` in 1: one-cycle pulse; win or loss, stops the timer.
- `clear` in 1: one-cycle pulse; new game, returns to IDLE with zero count.
- `tick` out 1: one-cycle pulse per elapsed period.
- `running` out 1: high in RUNNING.
- `seconds_bcd` out 12: {hundreds, tens, units} BCD.
- `seconds_bin` out 10: same value in binary.
- `saturated` out 1: high while count == `MAX_SECONDS`.

## Operation
- States, held in `timer_state_t`:
  - IDLE: count 0, prescaler 0, no ticks.
  - RUNNING: prescaler advances.
  - PAUSED: prescaler and count frozen.
  - STOPPED: count held for display.
- Transitions, checked in priority order `clear` > `game_over` > `start` > `pause`:
  - Any state, `clear` → IDLE. Count and prescaler are zeroed.
  - RUNNING or PAUSED, `game_over` → STOPPED.
  - IDLE, `start` → RUNNING. Prescaler is loaded with 0.
  - RUNNING, `pause`=1 → PAUSED.
  - PAUSED, `pause`=0 → RUNNING. The prescaler resumes from its held value; no partial period is lost.
- Ignored inputs:
  - `start` outside IDLE.
  - `game_over` in IDLE or STOPPED.
- Prescaler:
  - Width `$clog2(DIV)`.
  - Counts 0..DIV-1 and wraps to 0.
  - Increments only in RUNNING, on cycles where no transition out of RUNNING fires.
- Tick and count:
  - `tick` = 1 exactly on cycles where the state is RUNNING, the prescaler == DIV-1, and none of `clear`, `game_over`, `pause` is asserted.
  - On a tick, count increments by 1 in both the BCD and binary copies. The BCD copy uses per-digit carry, 9→0 with carry into the next digit.
  - At `MAX_SECONDS` the count holds and `saturated`=1. `tick` keeps pulsing, so downstream animation continues.
- Reset values: state IDLE, prescaler 0, `tick` 0, `running` 0, `seconds_bcd` 12'h000, `seconds_bin` 0, `saturated` 0.
- Reset mid-operation: all of the above apply immediately (asynchronous). No tick is emitted on the edge where `rst_n` deasserts.

## Timing
- All outputs are registered.
- `tick` is high for one cycle.
- The count update is visible on the cycle after the `tick` cycle.
- First tick after `start`: `tick` is high on the DIV-th cycle after the `start` cycle (`start` sampled at edge N; tick high during cycle N+DIV).
- `running` rises one cycle after `start` is sampled and falls one cycle after `pause`, `game_over` or `clear` is sampled.
- A cycle where `pause` rises while the prescaler == DIV-1 produces no tick. That tick occurs after resume, once the prescaler wraps from its held value DIV-1.
- `start` and `clear` in the same cycle: `clear` wins; the state stays IDLE.

## Structure
- Package `game_timer_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, STOPPED} timer_state_t`.
  - Localparam `BCD_W = 12`.
  - Function `bcd_inc3(logic [11:0]) -> logic [11:0]`, the 3-digit BCD incrementer.
- Sub-module `tick_prescaler`, parameter `DIV`:
  - Inputs `clk`, `rst_n`, `en`, `load0`.
  - Output `wrap`, high when count == DIV-1 and `en` is high.
- The top module holds the FSM, the count registers and the output registers.

## Test plan
Bench runs with `CLK_HZ`=10, `TICK_HZ`=1 (DIV=10), `MAX_SECONDS`=12 unless noted.
- Reset then `start` at cycle 0 → `running`=1 at cycle 1; `tick` at cycles 10, 20, 30; `seconds_bcd`=12'h003 after cycle 30.
- Run 4 cycles, `pause`=1 for 25 cycles, then `pause`=0 → no tick while paused; next tick exactly 6 running cycles after resume.
- Run past 12 ticks → `seconds_bcd` holds 12'h012, `saturated`=1, `tick` still pulses every 10 cycles.
- With `MAX_SECONDS`=999, force 9, 99 and 998 ticks → BCD 12'h009→12'h010, 12'h099→12'h100, 12'h998→12'h999 and `saturated`=1.
- `game_over` in the same cycle as prescaler == 9 → no tick, state STOPPED, count held. Then `clear` → IDLE, count 0. Then `start` and `clear` together → state stays IDLE.
- Assert `rst_n`=0 asynchronously mid-period → all outputs return to reset values before the next clock edge. After release, no tick until `start`.
